// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with sync clear, clamped parallel load, carry-out and wrap pulse.
// Define MODN_CNT_ONESHOT_EN to build the one-shot (stop at terminal value) mode.
module modn_updown_counter #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             oneshot_i,
    output logic [WIDTH-1:0] out_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             load_err_o,
    output logic             done_o
);

    generate
        if (N < 2 || N > (2 ** WIDTH)) begin : g_bad_modulus
            $error("modn_updown_counter: N=%0d outside legal range 2..2**WIDTH", N);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(N - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             done_q, done_d;
    logic             stop_at_tc;

`ifdef MODN_CNT_ONESHOT_EN
    assign stop_at_tc = oneshot_i;
`else
    logic unused_oneshot;
    assign unused_oneshot = oneshot_i;
    assign stop_at_tc     = 1'b0;
`endif

    always_comb begin
        out_d      = out_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        done_d     = done_q;
        if (clr_i) begin
            out_d  = '0;
            done_d = 1'b0;
        end else if (load_i) begin
            done_d = 1'b0;
            if (load_val_i > MAX_VAL) begin
                out_d      = MAX_VAL;
                load_err_d = 1'b1;
            end else begin
                out_d = load_val_i;
            end
        end else if (en_i && !done_q) begin
            // A corrupted (out of range) count recovers to 0 silently.
            if (out_q > MAX_VAL) begin
                out_d = '0;
            end else if (up_i) begin
                if (out_q == MAX_VAL) begin
                    if (stop_at_tc) begin
                        done_d = 1'b1;
                    end else begin
                        out_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q + 1'b1;
                end
            end else begin
                if (out_q == '0) begin
                    if (stop_at_tc) begin
                        done_d = 1'b1;
                    end else begin
                        out_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    out_d = out_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef MODN_CNT_ONESHOT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end
`else
    logic unused_done_d;
    assign unused_done_d = done_d;
    assign done_q        = 1'b0;
`endif

    assign out_o      = out_q;
    assign wrap_o     = wrap_q;
    assign load_err_o = load_err_q;
    assign done_o     = done_q;
    assign tc_o       = en_i & ~done_q & (up_i ? (out_q == MAX_VAL) : (out_q == '0));

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised modulo-N up/down counter: the successor to the fixed mod-10 counter. It counts over 0..N-1 in either direction and supports synchronous clear, parallel load with range clamping, a combinational carry for cascading, and a registered wrap pulse. An optional one-shot mode stops the count at the terminal value instead of wrapping. It is intended as the general counter/divider primitive for timers, BCD digit chains and clock-enable generators.

## Interface

- `N`, default 10: modulus; legal range 2..2**WIDTH. Illegal values must cause an elaboration error.
- `WIDTH`, default 4: counter width in bits.

- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `clr`, input, 1: synchronous clear to 0.
- `en`, input, 1: count enable.
- `up`, input, 1: direction; 1 = increment, 0 = decrement.
- `load`, input, 1: synchronous parallel load.
- `load_val`, input, WIDTH: value to load.
- `oneshot`, input, 1: one-shot mode select. Used only when `MODN_CNT_ONESHOT_EN` is defined.
- `out`, output, WIDTH: current count, registered.
- `tc`, output, 1: combinational terminal-count/carry. `tc = en & (up ? out==N-1 : out==0)`.
- `wrap`, output, 1: registered one-cycle pulse on wrap-around.
- `load_err`, output, 1: registered one-cycle pulse when a load value is out of range.
- `done`, output, 1: sticky one-shot completion flag, registered.

## Operation

- **Priority per edge:** `rst` > `clr` > `load` > `en` count > hold.
- **`rst`:** takes effect immediately, with no clock edge. Sets `out`=0, `wrap`=0, `load_err`=0, `done`=0.
- **`clr`:**
  - `out`←0 and `done`←0.
  - `wrap` and `load_err` are 0 on the following cycle.
  - `load` and `en` are ignored in that cycle.
- **`load`:**
  - If `load_val` ≤ N-1: `out`←`load_val`.
  - Otherwise: `out`←N-1 and `load_err` pulses high for one cycle.
  - `done`←0 in both cases; `en` is ignored in that cycle.
- **Count** (`en`=1, no higher-priority request):
  - Up: `out`←`out`+1, except `out`=N-1 goes to 0 with `wrap` pulsed.
  - Down: `out`←`out`-1, except `out`=0 goes to N-1 with `wrap` pulsed.
- **Hold:** when `en`=0, `out` holds and `wrap`=0.
- **Direction change:** `up` is sampled every edge and may change on any cycle. The next step uses the new direction.
- **Out-of-range `out`:** unreachable except through a corrupted state. If `out` > N-1 while counting, the next value is 0 and no `wrap` is asserted.
- **Cascading:** drive the next stage's `en` with this stage's `tc`. The next stage then advances on the same edge where this stage wraps.
- **Arithmetic:** use WIDTH-bit unsigned arithmetic. The N=2**WIDTH case must wrap correctly with no overflow artefacts.

## Timing

- `out`, `wrap`, `load_err` and `done` are registered and change only on the rising `clk` edge, except on assertion of `rst`.
- Latency from an `en`/`load`/`clr` sample edge to the new `out` value: 1 cycle.
- `wrap` is high in the same cycle that `out` shows the wrapped value (0 going up, N-1 going down).
- `tc` is combinational from `en`, `up` and `out`, with zero latency. It is high during the cycle before the wrap edge.
- `rst` deassertion: the first count occurs on the first rising edge after release on which `en`=1.
- `rst` asserted mid-count: every output except `tc` is forced to its reset value immediately. `tc` equals `en & ~up` while `out`=0.

## Configuration

- **`MODN_CNT_ONESHOT_EN` defined:**
  - When `oneshot`=1, a count step that would wrap is suppressed instead.
  - `out` stays at the terminal value (N-1 up, 0 down), `wrap` stays 0, and `done`←1.
  - While `done`=1, `en` has no effect.
  - `done` is cleared by `rst`, `clr` or `load`.
  - `tc` is forced to 0 while `done`=1.
- **`MODN_CNT_ONESHOT_EN` not defined:**
  - The `oneshot` input is ignored and `done` is tied to 0.
  - The counter always wraps, and no one-shot logic is synthesised.

## Test plan

- **Free-run up, N=10:** `rst` pulse, then `en`=1, `up`=1 for 12 cycles. Expect `out`=0,1,…,9,0,1,2. `wrap` is high only when `out` returns to 0. `tc` is high while `out`=9.
- **Down with direction flip, N=10:** load 2, then `up`=0 for 4 cycles. Expect `out`=1,0,9,8, with `wrap` at 9. Then set `up`=1; expect 9 on the next edge.
- **Load clamp:** N=10, `load_val`=13. Expect `out`=9 and `load_err` pulsing for exactly 1 cycle. `load_val`=5 gives `out`=5 with no `load_err`.
- **Priority:** assert `clr`, `load` (`load_val`=7) and `en` together. Expect `out`=0. Then `load`+`en` together gives `out`=7, not 8.
- **Async reset mid-count:** N=16, WIDTH=4, `out`=11. Raise `rst` between edges. Expect `out`=0 before the next edge. After release with `en`=1, the count goes 1,2…, wrapping from 15 to 0.
- **One-shot (macro defined), N=10:** `oneshot`=1, `up`=1, start from 7. Expect 8, 9, then `out` holds at 9 with `done`=1, `wrap`=0 and `tc`=0. A `load` of 3 clears `done`. Without the macro, the same stimulus wraps 9→0 and `done` stays 0.
